// File: rtl/core_ctrl_fsm_pkg.sv
// core_pkg: shared definitions for the RV32I multi-cycle control path.
// It holds the opcode constants, the datapath select encodings, the
// controller state enum and the instruction class enum. The class enum is
// shared by the class decoder and by anything downstream, such as hazard logic.
package core_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_PC_IMM = 2'b01;
  localparam logic [1:0] PCSRC_RS1IMM = 2'b10;

  localparam logic [1:0] WBSEL_ALU  = 2'b00;
  localparam logic [1:0] WBSEL_LOAD = 2'b01;
  localparam logic [1:0] WBSEL_PC4  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_CMP   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } ctrl_state_e;

  typedef enum logic [3:0] {
    CLS_NONE,
    CLS_LUI,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR,
    CLS_BRANCH,
    CLS_LOAD,
    CLS_STORE,
    CLS_OP_IMM,
    CLS_OP,
    CLS_FENCE,
    CLS_SYSTEM
  } instr_class_e;

endpackage

// File: rtl/core_ctrl_fsm_if.sv
// core_ctrl_fsm_if: the shared memory port handshake.
// The master is the controller. It drives memReq, memWe and memSel.
// The slave is the memory side. It drives memReady.
interface core_ctrl_fsm_if;
  logic memReq;
  logic memWe;
  logic memSel;
  logic memReady;

  modport master (output memReq, memWe, memSel, input memReady);
  modport slave  (input memReq, memWe, memSel, output memReady);
endinterface

// File: rtl/core_ctrl_fsm_decode.sv
// instr_class_decode: a purely combinational classifier.
// Inputs : opcode[6:0] and funct3[2:0], both taken from the instruction register.
// Outputs: cls is the instruction class.
//          illegal is high for an unknown opcode or a reserved funct3.
// Every defined opcode ends in 2'b11. An opcode whose low bits are not 11
// therefore falls into the default branch and is flagged illegal.
module instr_class_decode
  import core_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  output instr_class_e cls,
  output logic         illegal
);

  always_comb begin
    cls     = CLS_NONE;
    illegal = 1'b0;
    case (opcode)
      OPC_LUI:    cls = CLS_LUI;
      OPC_AUIPC:  cls = CLS_AUIPC;
      OPC_JAL:    cls = CLS_JAL;
      OPC_JALR: begin
        cls     = CLS_JALR;
        illegal = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        cls     = CLS_BRANCH;
        illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LOAD: begin
        cls     = CLS_LOAD;
        illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        cls     = CLS_STORE;
        illegal = (funct3 > 3'b010);
      end
      OPC_OP_IMM: cls = CLS_OP_IMM;
      OPC_OP:     cls = CLS_OP;
      OPC_FENCE:  cls = CLS_FENCE;
      OPC_SYSTEM: cls = CLS_SYSTEM;
      default: begin
        cls     = CLS_NONE;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm: the multi-cycle control sequencer for the RV32I core.
// Ports:
//   clk, areset (asynchronous, active-low)
//   opcode, funct3      : fields of the instruction register
//   branchTaken         : result of the ALU branch compare
//   mem (master)        : memReq/memWe/memSel out, memReady in
//   irWrite, pcLoad, pcSrc, regWrite, wbSel, aluOp, retire : datapath controls
//   illegal (sticky), halted, state : status and debug
//
// state   | meaning
// BOOT    | post-reset settle; a down-counter runs out BOOT_CYCLES cycles
// FETCH   | request the instruction at pc; capture it into IR on memReady
// DECODE  | classify the instruction; illegal encodings go to HALT
// EXEC    | ALU phase; branch, jump and fence retire here
// MEM     | load/store access at the ALU address; a store retires here
// WB      | register-file write; ALU ops and loads retire here
// HALT    | absorbing; left only through areset
//
// Outputs are decoded combinationally from the state register, so an
// asserted areset clears every strobe at once, even in mid-access.
module core_ctrl_fsm
  import core_pkg::*;
#(
  parameter int BOOT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                areset,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                branchTaken,
  core_ctrl_fsm_if.master     mem,
  output logic                irWrite,
  output logic                pcLoad,
  output logic [1:0]          pcSrc,
  output logic                regWrite,
  output logic [1:0]          wbSel,
  output logic [1:0]          aluOp,
  output logic                retire,
  output logic                illegal,
  output logic                halted,
  output logic [2:0]          state
);

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  ctrl_state_e  state_q;
  logic [3:0]   boot_cnt;
  logic         illegal_q;

  instr_class_e cls;
  logic         dec_illegal;

  logic         mem_req;
  logic         mem_we;
  logic         mem_sel;

  instr_class_decode u_decode (
    .opcode  (opcode),
    .funct3  (funct3),
    .cls     (cls),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q   <= ST_BOOT;
      boot_cnt  <= BOOT_LAST;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          if (boot_cnt == 4'd0) state_q <= ST_FETCH;
          else                  boot_cnt <= boot_cnt - 4'd1;
        end
        ST_FETCH: begin
          if (mem.memReady) state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          if (dec_illegal) begin
            state_q   <= ST_HALT;
            illegal_q <= 1'b1;
          end else begin
            state_q   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (cls)
            CLS_OP, CLS_OP_IMM, CLS_LUI, CLS_AUIPC: state_q <= ST_WB;
            CLS_LOAD, CLS_STORE:                    state_q <= ST_MEM;
            CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_FENCE: state_q <= ST_FETCH;
            default:                                state_q <= ST_HALT;
          endcase
        end
        ST_MEM: begin
          if (mem.memReady) state_q <= (cls == CLS_STORE) ? ST_FETCH : ST_WB;
        end
        ST_WB:   state_q <= ST_FETCH;
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_HALT;
      endcase
    end
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_sel  = 1'b0;
    irWrite  = 1'b0;
    pcLoad   = 1'b0;
    pcSrc    = PCSRC_PLUS4;
    regWrite = 1'b0;
    wbSel    = WBSEL_ALU;
    aluOp    = ALUOP_ADD;
    retire   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        irWrite = mem.memReady;
      end
      ST_EXEC: begin
        case (cls)
          CLS_OP, CLS_OP_IMM: aluOp = ALUOP_FUNCT;
          CLS_BRANCH: begin
            aluOp  = ALUOP_CMP;
            pcLoad = 1'b1;
            pcSrc  = branchTaken ? PCSRC_PC_IMM : PCSRC_PLUS4;
            retire = 1'b1;
          end
          CLS_JAL, CLS_JALR: begin
            regWrite = 1'b1;
            wbSel    = WBSEL_PC4;
            pcLoad   = 1'b1;
            pcSrc    = (cls == CLS_JAL) ? PCSRC_PC_IMM : PCSRC_RS1IMM;
            retire   = 1'b1;
          end
          CLS_FENCE: begin
            pcLoad = 1'b1;
            retire = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = (cls == CLS_STORE);
        if (mem.memReady && cls == CLS_STORE) begin
          pcLoad = 1'b1;
          retire = 1'b1;
        end
      end
      ST_WB: begin
        regWrite = 1'b1;
        wbSel    = (cls == CLS_LOAD) ? WBSEL_LOAD : WBSEL_ALU;
        pcLoad   = 1'b1;
        retire   = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem.memReq = mem_req;
  assign mem.memWe  = mem_we;
  assign mem.memSel = mem_sel;

  assign illegal = illegal_q;
  assign halted  = (state_q == ST_HALT);
  assign state   = state_q;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
module tb_core_ctrl_fsm;
  import core_pkg::*;

  localparam int BOOT = 2;

  logic       clk = 1'b0;
  logic       areset = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       branchTaken = 1'b0;
  logic       irWrite, pcLoad, regWrite, retire, illegal, halted;
  logic [1:0] pcSrc, wbSel, aluOp;
  logic [2:0] state;

  core_ctrl_fsm_if mem_if();

  core_ctrl_fsm #(.BOOT_CYCLES(BOOT)) dut (
    .clk(clk), .areset(areset), .opcode(opcode), .funct3(funct3),
    .branchTaken(branchTaken), .mem(mem_if), .irWrite(irWrite),
    .pcLoad(pcLoad), .pcSrc(pcSrc), .regWrite(regWrite), .wbSel(wbSel),
    .aluOp(aluOp), .retire(retire), .illegal(illegal), .halted(halted),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       req, we, sel, irw, pcl;
    logic [1:0] pcs;
    logic       rw;
    logic [1:0] wbs, alu;
    logic       ret, ill, hlt;
    logic [2:0] st;
  } exp_t;

  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    logic       bt;
    logic       rdy;
    exp_t       e;
    int         idx;
  } cyc_t;

  cyc_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   instr_idx = 0;
  int   n_ret_exp = 0;
  int   n_pcl = 0;
  int   n_ret = 0;
  int   cyc_since_reset = 0;
  int   first_req = -1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
    end
  endtask

  function automatic exp_t act_vec();
    exp_t a;
    a.req = mem_if.memReq; a.we = mem_if.memWe; a.sel = mem_if.memSel;
    a.irw = irWrite; a.pcl = pcLoad; a.pcs = pcSrc; a.rw = regWrite;
    a.wbs = wbSel; a.alu = aluOp; a.ret = retire; a.ill = illegal;
    a.hlt = halted; a.st = state;
    return a;
  endfunction

  function automatic bit is_legal(input logic [6:0] o, input logic [2:0] f);
    case (o)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP_IMM, OPC_OP, OPC_FENCE, OPC_SYSTEM: return 1'b1;
      OPC_JALR:   return f == 3'd0;
      OPC_BRANCH: return !(f == 3'd2 || f == 3'd3);
      OPC_LOAD:   return f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      OPC_STORE:  return f <= 3'd2;
      default:    return 1'b0;
    endcase
  endfunction

  task automatic push(input logic [6:0] o, input logic [2:0] f, input logic bt,
                      input logic rdy, input exp_t e);
    cyc_t c;
    c.opc = o; c.f3 = f; c.bt = bt; c.rdy = rdy; c.e = e; c.idx = instr_idx;
    q.push_back(c);
  endtask

  // Per-instruction cycle schedule: fetch with wf wait cycles, decode, then the
  // class-specific tail, with wm wait cycles on the data access.
  task automatic gen_instr(input logic [6:0] o, input logic [2:0] f, input logic bt,
                           input int wf, input int wm);
    exp_t e;
    bit ld, st;
    instr_idx++;
    for (int i = 0; i <= wf; i++) begin
      e = '0; e.st = 3'd1; e.req = 1'b1; e.irw = (i == wf);
      push(7'($urandom), 3'($urandom), 1'($urandom), (i == wf), e);
    end
    e = '0; e.st = 3'd2;
    push(o, f, 1'($urandom), 1'($urandom), e);
    if (!is_legal(o, f)) return;
    ld = (o == OPC_LOAD);
    st = (o == OPC_STORE);
    e = '0; e.st = 3'd3;
    if (o == OPC_OP || o == OPC_OP_IMM || o == OPC_LUI || o == OPC_AUIPC) begin
      e.alu = (o == OPC_OP || o == OPC_OP_IMM) ? 2'b10 : 2'b00;
      push(o, f, 1'($urandom), 1'($urandom), e);
      e = '0; e.st = 3'd5; e.rw = 1'b1; e.pcl = 1'b1; e.ret = 1'b1;
      push(o, f, 1'($urandom), 1'($urandom), e);
      n_ret_exp++;
    end else if (ld || st) begin
      push(o, f, 1'($urandom), 1'($urandom), e);
      for (int i = 0; i <= wm; i++) begin
        e = '0; e.st = 3'd4; e.req = 1'b1; e.sel = 1'b1; e.we = st;
        if (st && i == wm) begin e.pcl = 1'b1; e.ret = 1'b1; end
        push(o, f, 1'($urandom), (i == wm), e);
      end
      if (ld) begin
        e = '0; e.st = 3'd5; e.rw = 1'b1; e.wbs = 2'b01; e.pcl = 1'b1; e.ret = 1'b1;
        push(o, f, 1'($urandom), 1'($urandom), e);
      end
      n_ret_exp++;
    end else if (o == OPC_BRANCH) begin
      e.alu = 2'b01; e.pcl = 1'b1; e.ret = 1'b1; e.pcs = bt ? 2'b01 : 2'b00;
      push(o, f, bt, 1'($urandom), e);
      n_ret_exp++;
    end else if (o == OPC_JAL || o == OPC_JALR) begin
      e.rw = 1'b1; e.wbs = 2'b10; e.pcl = 1'b1; e.ret = 1'b1;
      e.pcs = (o == OPC_JAL) ? 2'b01 : 2'b10;
      push(o, f, 1'($urandom), 1'($urandom), e);
      n_ret_exp++;
    end else if (o == OPC_FENCE) begin
      e.pcl = 1'b1; e.ret = 1'b1;
      push(o, f, 1'($urandom), 1'($urandom), e);
      n_ret_exp++;
    end else begin
      push(o, f, 1'($urandom), 1'($urandom), e);
    end
  endtask

  task automatic gen_halt(input int n, input logic ill);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = '0; e.st = 3'd6; e.hlt = 1'b1; e.ill = ill;
      push(7'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), e);
    end
  endtask

  // The single compare process: apply each scheduled cycle's inputs on the
  // falling edge, then check all outputs against the schedule.
  task automatic run_q(input int n);
    cyc_t c;
    exp_t a;
    for (int k = 0; k < n && q.size() > 0; k++) begin
      c = q.pop_front();
      opcode = c.opc; funct3 = c.f3; branchTaken = c.bt; mem_if.memReady = c.rdy;
      #2;
      a = act_vec();
      checks++;
      if (a != c.e) begin
        errors++;
        $display("FAIL outputs instr=%0d t=%0t actual=%05h required=%05h",
                 c.idx, $time, a, c.e);
      end
      if (pcLoad) n_pcl++;
      if (retire) n_ret++;
      if (mem_if.memReq && first_req < 0) first_req = cyc_since_reset;
      cyc_since_reset++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input bit tie_rdy);
    exp_t e;
    #3;
    areset = 1'b0;
    mem_if.memReady = 1'b1;
    #1;
    chk("reset_async_zero", int'(act_vec()), 0);
    @(negedge clk);
    #2;
    chk("reset_hold_zero", int'(act_vec()), 0);
    @(negedge clk);
    areset = 1'b1;
    cyc_since_reset = 0;
    first_req = -1;
    q.delete();
    for (int i = 0; i < BOOT; i++) begin
      e = '0;
      push(7'($urandom), 3'($urandom), 1'($urandom), tie_rdy ? 1'b1 : 1'($urandom), e);
    end
    run_q(BOOT);
  endtask

  task automatic rand_legal(output logic [6:0] o, output logic [2:0] f);
    logic [6:0] opcs [11];
    opcs = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
             OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_FENCE, OPC_LOAD};
    o = opcs[$urandom_range(0, 10)];
    do f = 3'($urandom); while (!is_legal(o, f));
  endtask

  task automatic rand_illegal(output logic [6:0] o, output logic [2:0] f);
    case ($urandom_range(0, 5))
      0: begin o = 7'($urandom) & 7'b1111100; f = 3'($urandom); end
      1: begin o = OPC_BRANCH; f = 3'($urandom_range(2, 3)); end
      2: begin o = OPC_LOAD;   f = ($urandom_range(0, 1) != 0) ? 3'd3 : 3'($urandom_range(6, 7)); end
      3: begin o = OPC_STORE;  f = 3'($urandom_range(3, 7)); end
      4: begin o = OPC_JALR;   f = 3'($urandom_range(1, 7)); end
      default: begin o = 7'b1111111; f = 3'($urandom); end
    endcase
  endtask

  initial begin
    logic [6:0] o;
    logic [2:0] f;
    mem_if.memReady = 1'b1;
    @(negedge clk);
    do_reset(1'b1);

    // Schedules that follow are pinned against hand-counted cycle totals.
    gen_instr(OPC_OP_IMM, 3'd0, 1'b0, 0, 0);
    chk("len_addi", q.size(), 4);
    run_q(q.size());
    chk("first_fetch_cycle", first_req, 2);
    gen_instr(OPC_BRANCH, 3'd0, 1'b1, 0, 0);
    chk("len_beq_taken", q.size(), 3);
    run_q(q.size());
    gen_instr(OPC_BRANCH, 3'd0, 1'b0, 0, 0);
    chk("len_beq_not", q.size(), 3);
    run_q(q.size());
    gen_instr(OPC_LOAD, 3'd2, 1'b0, 0, 3);
    chk("len_load_wait3", q.size(), 8);
    run_q(q.size());
    gen_instr(OPC_STORE, 3'd2, 1'b0, 0, 0);
    chk("len_store", q.size(), 4);
    run_q(q.size());
    gen_instr(OPC_JAL, 3'd0, 1'b0, 1, 0);
    chk("len_jal_fetchwait", q.size(), 4);
    run_q(q.size());
    gen_instr(OPC_JALR, 3'd0, 1'b0, 0, 0);
    gen_instr(OPC_FENCE, 3'd0, 1'b0, 0, 0);
    gen_instr(OPC_LUI, 3'd0, 1'b0, 2, 0);
    gen_instr(OPC_OP, 3'd5, 1'b0, 0, 0);
    run_q(q.size());

    for (int i = 0; i < 150; i++) begin
      rand_legal(o, f);
      gen_instr(o, f, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      run_q(q.size());
    end

    // Reset while a load waits in MEM; the stale memReady must not advance BOOT.
    gen_instr(OPC_LOAD, 3'd0, 1'b0, 0, 6);
    n_ret_exp--;
    run_q(5);
    mem_if.memReady = 1'b0;
    #1;
    chk("mid_mem_state", int'(state), 4);
    chk("mid_mem_req", int'(mem_if.memReq), 1);
    do_reset(1'b0);

    gen_instr(OPC_SYSTEM, 3'd0, 1'b0, 0, 0);
    gen_halt(10, 1'b0);
    run_q(q.size());
    do_reset(1'b0);

    for (int i = 0; i < 6; i++) begin
      rand_legal(o, f);
      gen_instr(o, f, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
      run_q(q.size());
      rand_illegal(o, f);
      gen_instr(o, f, 1'b0, $urandom_range(0, 2), 0);
      gen_halt(5, 1'b1);
      run_q(q.size());
      do_reset(1'b0);
    end

    gen_instr(OPC_JALR, 3'd1, 1'b0, 0, 0);
    gen_halt(20, 1'b1);
    run_q(q.size());

    chk("pcload_count", n_pcl, n_ret_exp);
    chk("retire_count", n_ret, n_ret_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
